// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: two-requester round-robin arbiter driving a registered 2:1 data mux.
// Optional macro HOLD_LIMIT_EN caps consecutive grant cycles at MAX_HOLD while the other side waits.
`default_nettype none

module rr_mux_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] dataIn0,
    input  logic [1:0] dataIn1,
    output logic       grant0,
    output logic       grant1,
    output logic       selector,
    output logic [1:0] dataOut,
    output logic       validOut
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   last_grant;

    if ((MAX_HOLD < 2) || (MAX_HOLD > 15)) begin : g_max_hold_range_check
        $error("rr_mux_arbiter: MAX_HOLD must lie in 2..15");
    end

`ifdef HOLD_LIMIT_EN
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
    logic [3:0] hold_cnt;
    logic       hold_expired;

    assign hold_expired = (hold_cnt == HOLD_LAST);
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    next_state = last_grant ? GRANT0 : GRANT1;
                else if (req0)
                    next_state = GRANT0;
                else if (req1)
                    next_state = GRANT1;
                else
                    next_state = IDLE;
            end
            GRANT0: begin
                if (!req0)
                    next_state = req1 ? GRANT1 : IDLE;
`ifdef HOLD_LIMIT_EN
                else if (req1 && hold_expired)
                    next_state = GRANT1;
`endif
            end
            GRANT1: begin
                if (!req1)
                    next_state = req0 ? GRANT0 : IDLE;
`ifdef HOLD_LIMIT_EN
                else if (req0 && hold_expired)
                    next_state = GRANT0;
`endif
            end
            default: next_state = IDLE;
        endcase
    end

    // Data capture follows the state held before the edge, so data trails the grant by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            selector   <= 1'b0;
            dataOut    <= 2'b00;
            validOut   <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == GRANT0) begin
                selector <= 1'b0;
                if (state != GRANT0)
                    last_grant <= 1'b0;
            end else if (next_state == GRANT1) begin
                selector <= 1'b1;
                if (state != GRANT1)
                    last_grant <= 1'b1;
            end
            case (state)
                GRANT0: begin
                    dataOut  <= dataIn0;
                    validOut <= 1'b1;
                end
                GRANT1: begin
                    dataOut  <= dataIn1;
                    validOut <= 1'b1;
                end
                default: validOut <= 1'b0;
            endcase
        end
    end

`ifdef HOLD_LIMIT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hold_cnt <= 4'd0;
        else if (next_state != state)
            hold_cnt <= 4'd0;
        else if ((state != IDLE) && !hold_expired)
            hold_cnt <= hold_cnt + 4'd1;
    end
`endif

    assign grant0 = (state == GRANT0);
    assign grant1 = (state == GRANT1);

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed vector table, corner sequences, random vs model.
`default_nettype none

module tb_rr_mux_arbiter;

    localparam int MAX_HOLD = 4;
`ifdef HOLD_LIMIT_EN
    localparam bit HOLD_ON = 1'b1;
`else
    localparam bit HOLD_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [1:0] dataIn0 = 2'b00;
    logic [1:0] dataIn1 = 2'b00;
    logic       grant0;
    logic       grant1;
    logic       selector;
    logic [1:0] dataOut;
    logic       validOut;

    int checks = 0;
    int errors = 0;

    rr_mux_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .dataIn0  (dataIn0),
        .dataIn1  (dataIn1),
        .grant0   (grant0),
        .grant1   (grant1),
        .selector (selector),
        .dataOut  (dataOut),
        .validOut (validOut)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the path, for how many edges, and whom a tie goes against.
    int         m_owner;
    int         m_last;
    int         m_cycles;
    logic       m_sel;
    logic [1:0] m_dout;
    logic       m_valid;

    task automatic model_reset();
        m_owner  = -1;
        m_last   = 1;
        m_cycles = 0;
        m_sel    = 1'b0;
        m_dout   = 2'b00;
        m_valid  = 1'b0;
    endtask

    task automatic model_edge();
        logic r [2];
        int   nxt;
        r[0] = req0;
        r[1] = req1;
        if (m_owner == 0) begin
            m_dout  = dataIn0;
            m_valid = 1'b1;
        end else if (m_owner == 1) begin
            m_dout  = dataIn1;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (m_owner < 0) begin
            if (r[0] && r[1])  nxt = 1 - m_last;
            else if (r[0])     nxt = 0;
            else if (r[1])     nxt = 1;
            else               nxt = -1;
        end else if (!r[m_owner]) begin
            nxt = r[1 - m_owner] ? 1 - m_owner : -1;
        end else if (HOLD_ON && r[1 - m_owner] && (m_cycles >= MAX_HOLD)) begin
            nxt = 1 - m_owner;
        end else begin
            nxt = m_owner;
        end
        if (nxt >= 0 && nxt != m_owner) begin
            m_last   = nxt;
            m_cycles = 1;
        end else if (nxt >= 0) begin
            m_cycles = m_cycles + 1;
        end
        if (nxt >= 0)
            m_sel = (nxt == 1);
        m_owner = nxt;
    endtask

    task automatic expect_out(input string name, input logic g0, input logic g1,
                              input logic sel, input logic [1:0] d, input logic v);
        checks++;
        if ({grant0, grant1, selector, dataOut, validOut} !== {g0, g1, sel, d, v}) begin
            errors++;
            $display("FAIL %s: got g0=%b g1=%b sel=%b dout=%b valid=%b, want g0=%b g1=%b sel=%b dout=%b valid=%b",
                     name, grant0, grant1, selector, dataOut, validOut, g0, g1, sel, d, v);
        end
    endtask

    task automatic check_model(input string name);
        expect_out(name, m_owner == 0, m_owner == 1, m_sel, m_dout, m_valid);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (grant0 && grant1) begin
            checks++;
            errors++;
            $display("FAIL exclusive_grants: got g0=%b g1=%b, want at most one", grant0, grant1);
        end
    end

    typedef struct {
        logic       r0;
        logic       r1;
        logic [1:0] d0;
        logic [1:0] d1;
        logic       g0;
        logic       g1;
        logic       sel;
        logic [1:0] dout;
        logic       v;
    } vec_t;

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 2'b11, 2'b10, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 2'b10, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 2'b10, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};

        model_reset();
        #1;
        expect_out("reset_state", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            req0    = tbl[i].r0;
            req1    = tbl[i].r1;
            dataIn0 = tbl[i].d0;
            dataIn1 = tbl[i].d1;
            step();
            expect_out($sformatf("vector_%0d", i), tbl[i].g0, tbl[i].g1, tbl[i].sel,
                       tbl[i].dout, tbl[i].v);
        end

        // Sustained tie straight out of reset: alternation only when the hold limit is built in.
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic want0;
            want0 = HOLD_ON ? (((i / 4) % 2) == 0) : 1'b1;
            step();
            checks++;
            if ({grant0, grant1, selector} !== {want0, ~want0, ~want0}) begin
                errors++;
                $display("FAIL tie_hold_cycle_%0d: got g0=%b g1=%b sel=%b, want g0=%b g1=%b sel=%b",
                         i, grant0, grant1, selector, want0, ~want0, ~want0);
            end
        end

        // Asynchronous reset in the middle of a GRANT1 cycle.
        do_reset();
        req0    = 1'b0;
        req1    = 1'b1;
        dataIn1 = 2'b01;
        step();
        check_model("grant1_entry");
        step();
        check_model("grant1_data");
        #2;
        reset = 1'b1;
        #1;
        expect_out("async_reset_mid_grant", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        req1  = 1'b0;
        step();
        check_model("after_reset_idle");
        req0    = 1'b1;
        dataIn0 = 2'b10;
        step();
        check_model("after_reset_grant0");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
                #1;
                check_model("random_reset");
            end
            req0    = ($urandom_range(0, 3) != 0);
            req1    = ($urandom_range(0, 3) != 0);
            dataIn0 = 2'($urandom_range(0, 3));
            dataIn1 = 2'($urandom_range(0, 3));
            step();
            check_model($sformatf("random_%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
